// File: rtl/chronos_pkg.sv
// Shared chronos definitions: logging enables, log word type, read FSM states
// and the OCL register offsets of the per-tile debug log.
package chronos;

    localparam int LOG_LOG_DEPTH = 14;

    // Per-tile logging enables; bit N set means tile N instantiates a log.
    localparam int TASK_UNIT_LOGGING = 1;
    localparam int CQ_LOGGING        = 0;
    localparam int L2_LOGGING        = 0;

    typedef logic [31:0] log_word_t;

    localparam logic [15:0] OCL_LOG_RD_START   = 16'h0200;
    localparam logic [15:0] OCL_LOG_RD_DATA    = 16'h0204;
    localparam logic [15:0] OCL_LOG_COUNT      = 16'h0208;
    localparam logic [15:0] OCL_LOG_DROP_COUNT = 16'h020C;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_OUT   = 2'd2
    } log_rd_state_t;

    // Number of 32-bit words one stored entry drains as.
    function automatic int log_words(input int entry_width, input bit with_ts);
        return entry_width / 32 + (with_ts ? 1 : 0);
    endfunction

endpackage

// File: rtl/debug_log_ram.sv
// Simple dual-port RAM with a registered read port, kept on its own so the
// storage maps cleanly onto block RAM.
module debug_log_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage and its read register have no reset; a reset would stop
    // block-RAM inference, and contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/debug_log_buffer.sv
// Per-tile circular debug log drained as 32-bit words over the OCL read path.
// Define DEBUG_LOG_TIMESTAMP_EN to prepend a 32-bit cycle stamp to each entry.
module debug_log_buffer
    import chronos::*;
#(
    parameter int LOG_DEPTH    = LOG_LOG_DEPTH,
    parameter int ENTRY_WIDTH  = 128,
    parameter int TILE_ID      = 0,
    parameter int LOGGING_MASK = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   log_valid,
    input  logic [ENTRY_WIDTH-1:0] log_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_data,
    input  logic                   rd_start,
    input  logic                   clear,
    output logic [LOG_DEPTH:0]     count,
    output logic [31:0]            drop_count
);

    localparam bit ENABLED = ((LOGGING_MASK >> TILE_ID) & 1) != 0;

    generate
        if (ENABLED) begin : g_log
`ifdef DEBUG_LOG_TIMESTAMP_EN
            localparam bit TS_EN = 1'b1;
`else
            localparam bit TS_EN = 1'b0;
`endif
            localparam int NWORDS = log_words(ENTRY_WIDTH, TS_EN);
            localparam int MEM_W  = NWORDS * 32;
            localparam int PTR_W  = LOG_DEPTH;
            localparam int CNT_W  = LOG_DEPTH + 1;
            localparam int IDX_W  = $clog2(NWORDS + 1);
            localparam int DEPTH  = 1 << LOG_DEPTH;

            log_rd_state_t     state, state_next;
            logic [PTR_W-1:0]  wr_ptr, rd_ptr;
            logic [CNT_W-1:0]  cnt;
            logic [31:0]       drops;
            logic [MEM_W-1:0]  wr_word, ram_q, shreg;
            logic [IDX_W-1:0]  word_idx;
            logic              full, push, drop, rd_issue, accept, pop;

            assign full   = (cnt == CNT_W'(DEPTH));
            assign push   = log_valid && !full;
            assign drop   = log_valid && full;
            assign accept = (state == RD_OUT) && rd_ready;
            assign pop    = accept && (word_idx == IDX_W'(NWORDS - 1));

`ifdef DEBUG_LOG_TIMESTAMP_EN
            logic [31:0] ts_cnt;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    ts_cnt <= '0;
                end else begin
                    ts_cnt <= ts_cnt + 32'd1;
                end
            end

            // Stamp sits in the low word so it drains ahead of the payload.
            assign wr_word = {log_data, ts_cnt};
`else
            assign wr_word = log_data;
`endif

            debug_log_ram #(
                .ADDR_W (PTR_W),
                .DATA_W (MEM_W)
            ) u_ram (
                .clk     (clk),
                .wr_en   (push && !clear),
                .wr_addr (wr_ptr),
                .wr_data (wr_word),
                .rd_en   (rd_issue),
                .rd_addr (rd_ptr),
                .rd_data (ram_q)
            );

            // NOTE: every combinational output gets a default first so no
            // path through the case leaves it unassigned and infers a latch.
            always_comb begin
                state_next = state;
                rd_issue   = 1'b0;
                case (state)
                    RD_IDLE: begin
                        if (rd_start && cnt != '0) begin
                            rd_issue   = 1'b1;
                            state_next = RD_FETCH;
                        end
                    end
                    RD_FETCH: state_next = RD_OUT;
                    RD_OUT: begin
                        if (pop) begin
                            state_next = RD_IDLE;
                        end
                    end
                    default: state_next = RD_IDLE;
                endcase
                if (clear) begin
                    rd_issue   = 1'b0;
                    state_next = RD_IDLE;
                end
            end

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    state <= RD_IDLE;
                end else begin
                    state <= state_next;
                end
            end

            // clear wins over a concurrent write or pop; that record is lost
            // silently and does not count as a drop.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    drops  <= '0;
                end else if (clear) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    drops  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    if (push && !pop) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (pop && !push) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    if (drop && drops != '1) begin
                        drops <= drops + 32'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    shreg    <= '0;
                    word_idx <= '0;
                end else if (state == RD_FETCH) begin
                    shreg    <= ram_q;
                    word_idx <= '0;
                end else if (accept) begin
                    shreg    <= shreg >> 32;
                    word_idx <= word_idx + IDX_W'(1);
                end
            end

            assign rd_valid   = (state == RD_OUT);
            assign rd_data    = shreg[31:0];
            assign count      = cnt;
            assign drop_count = drops;
        end else begin : g_off
            assign rd_valid   = 1'b0;
            assign rd_data    = '0;
            assign count      = '0;
            assign drop_count = '0;
        end
    endgenerate

endmodule

// File: tb/tb_debug_log_buffer.sv
// Scoreboard bench for debug_log_buffer at LOG_DEPTH=4 (16 entries).
module tb_debug_log_buffer;

    localparam int LD = 4;
    localparam int DEPTH = 16;
`ifdef DEBUG_LOG_TIMESTAMP_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif

    logic         clk = 1'b0;
    logic         rstn, log_valid, rd_valid, rd_ready, rd_start, clear;
    logic [127:0] log_data;
    logic [31:0]  rd_data, drop_count;
    logic [LD:0]  count;

    int vectors = 0;
    int miscompares = 0;

    logic [159:0] exp_q[$];
    logic [159:0] head;
    int           widx = 0;
    bit           full_b;

    always #5 clk = ~clk;

    debug_log_buffer #(
        .LOG_DEPTH    (LD),
        .ENTRY_WIDTH  (128),
        .TILE_ID      (0),
        .LOGGING_MASK (1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .log_valid  (log_valid),
        .log_data   (log_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_start   (rd_start),
        .clear      (clear),
        .count      (count),
        .drop_count (drop_count)
    );

`ifdef DEBUG_LOG_TIMESTAMP_EN
    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: records enter on accepted writes, words leave on handshakes.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            widx = 0;
        end else begin
            full_b = (exp_q.size() == DEPTH);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", rd_valid, 0);
                end else begin
                    head = exp_q[0];
                    check("rd_data", rd_data, head[widx*32 +: 32]);
                    if (rd_ready && !clear) begin
                        if (widx == NW - 1) begin
                            void'(exp_q.pop_front());
                            widx = 0;
                        end else begin
                            widx++;
                        end
                    end
                end
            end
            if (clear) begin
                exp_q.delete();
                widx = 0;
            end else if (log_valid && !full_b) begin
`ifdef DEBUG_LOG_TIMESTAMP_EN
                exp_q.push_back({log_data, 32'(cyc)});
`else
                exp_q.push_back({32'h0, log_data});
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] make_rec(input int i);
        return {32'h3000_0000 | 32'(i), 32'h2000_0000 | 32'(i),
                32'h1000_0000 | 32'(i), 32'(i)};
    endfunction

    task automatic write_rec(input logic [127:0] d);
        log_valid = 1'b1;
        log_data  = d;
        tick();
        log_valid = 1'b0;
    endtask

    // Drains n entries, applying the 4-step rd_ready pattern while valid.
    task automatic drain(input int n, input logic [3:0] pat);
        for (int e = 0; e < n; e++) begin
            int b = 0;
            int k = 0;
            rd_start = 1'b1;
            rd_ready = pat[0];
            tick();
            rd_start = 1'b0;
            while (!rd_valid && b < 8) begin
                tick();
                b++;
            end
            if (!rd_valid) check("drain_start", rd_valid, 1);
            while (rd_valid && b < 200) begin
                rd_ready = pat[k % 4];
                tick();
                k++;
                b++;
            end
            if (rd_valid) check("drain_end", rd_valid, 0);
        end
        rd_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; log_valid = 1'b0; log_data = '0;
        rd_ready = 1'b0; rd_start = 1'b0; clear = 1'b0;
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_valid", rd_valid, 0);
        rstn = 1'b1;
        tick();

        // Single record, rd_start and rd_ready held high.
        write_rec(128'h0000_0004_0000_0003_0000_0002_0000_0001);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        check("t1_count1", count, 1);
        check("t1_lat0", rd_valid, 0);
        tick();
        check("t1_lat1", rd_valid, 0);
        tick();
        check("t1_lat2", rd_valid, 1);
        check("t1_word0", rd_data, 32'd1);
        repeat (4) tick();
        check("t1_count0", count, 0);
        check("t1_valid_drop", rd_valid, 0);
        tick();
        check("t1_start_empty", rd_valid, 0);
        rd_start = 1'b0;

        // Fill past capacity.
        for (int i = 0; i < DEPTH + 3; i++) write_rec(make_rec(i));
        check("t2_count_full", count, DEPTH);
        check("t2_drops", drop_count, 3);
        drain(DEPTH, 4'b1111);
        check("t2_count_empty", count, 0);
        check("t2_drops_kept", drop_count, 3);

        // Backpressure 1,0,0,1.
        write_rec(make_rec(100));
        write_rec(make_rec(101));
        drain(2, 4'b1001);
        check("t3_count", count, 0);

        // Write and pop in the same cycle with 5 held.
        for (int i = 0; i < 5; i++) write_rec(make_rec(200 + i));
        check("t4_count_pre", count, 5);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        check("t4_valid", rd_valid, 1);
        repeat (3) tick();
        log_valid = 1'b1;
        log_data  = make_rec(205);
        tick();
        log_valid = 1'b0;
        check("t4_count_same", count, 5);
        drain(5, 4'b1111);
        check("t4_count_empty", count, 0);

        // Pointer wrap with entries in flight.
        for (int i = 0; i < 3; i++) write_rec(make_rec(300 + i));
        for (int i = 0; i < 20; i++) begin
            write_rec(make_rec(400 + i));
            drain(1, 4'b1111);
        end
        check("t5_count3", count, 3);
        drain(3, 4'b1111);
        check("t5_count0", count, 0);

        // clear during OUT with a concurrent write.
        for (int i = 0; i < 3; i++) write_rec(make_rec(500 + i));
        rd_start = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        tick();
        check("t6_valid", rd_valid, 1);
        clear     = 1'b1;
        log_valid = 1'b1;
        log_data  = make_rec(599);
        tick();
        clear     = 1'b0;
        log_valid = 1'b0;
        check("t6_count", count, 0);
        check("t6_valid_off", rd_valid, 0);
        check("t6_drop", drop_count, 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        check("t6_start_ignored", rd_valid, 0);
        rd_ready = 1'b1;

        // Reset mid-drain.
        write_rec(make_rec(600));
        write_rec(make_rec(601));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        #1;
        check("t7_count", count, 0);
        check("t7_valid", rd_valid, 0);
        tick();
        rstn = 1'b1;

`ifdef DEBUG_LOG_TIMESTAMP_EN
        while (cyc != 10) tick();
        write_rec(make_rec(700));
        while (cyc != 25) tick();
        write_rec(make_rec(701));
        drain(2, 4'b1111);
        check("t8_count", count, 0);
`else
        write_rec(make_rec(700));
        check("t8_count", count, 1);
        drain(1, 4'b1111);
        check("t8_count0", count, 0);
`endif

        check("end_sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
